// File: rtl/tpu_pkg.sv
// Shared constants and types for the TPU C-buffer drain path.
// Holds the default bus widths, the lane geometry and the drain FSM state encoding.
package tpu_pkg;

    localparam int TPU_ADDR_BITS  = 16;
    localparam int TPU_DATA_BITS  = 32;
    localparam int TPU_DATAC_BITS = 128;
    localparam int LANES          = 4;
    localparam int LANE_BITS      = $clog2(LANES);
    localparam int WCNT_BITS      = 14;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        DONE
    } drain_state_t;

    typedef logic [WCNT_BITS-1:0] wcnt_t;

    // Number of 128-bit C words in an M x N result; the low two bits of N are dropped.
    function automatic wcnt_t word_count(input logic [7:0] m, input logic [7:0] n);
        return wcnt_t'(m) * wcnt_t'(n >> 2);
    endfunction

endpackage

// File: rtl/tpu_c_wordbuf.sv
// Two-entry C word buffer: a hold register that feeds the 32-bit lane mux
// and a prefetch register that catches returning read data.
module tpu_c_wordbuf
    import tpu_pkg::*;
#(
    parameter int DATA_BITS  = TPU_DATA_BITS,
    parameter int DATAC_BITS = TPU_DATAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATAC_BITS-1:0] load_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_BITS-1:0]  data,
    output logic                  last_lane,
    output logic                  pop,
    output logic [1:0]            count
);

    logic [DATAC_BITS-1:0] hold_q;
    logic [DATAC_BITS-1:0] pf_q;
    logic                  hold_v;
    logic                  pf_v;
    logic [LANE_BITS-1:0]  lane;

    assign valid     = hold_v;
    assign last_lane = (lane == LANE_BITS'(LANES - 1));
    assign pop       = hold_v && ready && last_lane;
    assign count     = {1'b0, hold_v} + {1'b0, pf_v};

    always_comb begin
        data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LANE_BITS'(i)) begin
                data = hold_q[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // When the hold word retires, prefetch slides into hold on the same edge so
    // the stream never sees a bubble between words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            pf_q   <= '0;
            hold_v <= 1'b0;
            pf_v   <= 1'b0;
            lane   <= '0;
        end else begin
            if (hold_v && ready) begin
                lane <= lane + 1'b1;
            end
            if (!hold_v || pop) begin
                if (pf_v) begin
                    hold_q <= pf_q;
                    hold_v <= 1'b1;
                    pf_v   <= load;
                    if (load) begin
                        pf_q <= load_data;
                    end
                end else if (load) begin
                    hold_q <= load_data;
                    hold_v <= 1'b1;
                end else begin
                    hold_v <= 1'b0;
                end
            end else if (load) begin
                pf_q <= load_data;
                pf_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tpu_c_drain.sv
// Drain stage: reads the M x (N/4) C result words after the controller finishes
// and streams them out as 32-bit AXI-Stream beats with full backpressure.
module tpu_c_drain
    import tpu_pkg::*;
#(
    parameter int ADDR_BITS  = TPU_ADDR_BITS,
    parameter int DATA_BITS  = TPU_DATA_BITS,
    parameter int DATAC_BITS = TPU_DATAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            M,
    input  logic [7:0]            N,
    output logic                  busy,
    output logic                  done,
    output logic                  C_rd_en,
    output logic [ADDR_BITS-1:0]  C_index,
    input  logic [DATAC_BITS-1:0] C_data_out,
    output logic                  sm_tvalid,
    output logic [DATA_BITS-1:0]  sm_tdata,
    output logic                  sm_tlast,
    input  logic                  sm_tready
);

    drain_state_t state;
    wcnt_t        w_total;
    wcnt_t        w_start;
    wcnt_t        rd_cnt;
    wcnt_t        sent_cnt;
    logic         arriving;
    logic         buf_valid;
    logic         buf_last_lane;
    logic         buf_pop;
    logic [1:0]   buf_count;
    logic [2:0]   committed;
    logic         final_hs;
    logic         issue;

    tpu_c_wordbuf #(
        .DATA_BITS  (DATA_BITS),
        .DATAC_BITS (DATAC_BITS)
    ) u_wordbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (arriving),
        .load_data (C_data_out),
        .ready     (sm_tready),
        .valid     (buf_valid),
        .data      (sm_tdata),
        .last_lane (buf_last_lane),
        .pop       (buf_pop),
        .count     (buf_count)
    );

    assign w_start   = word_count(M, N);
    assign sm_tvalid = buf_valid;
    assign sm_tlast  = buf_valid && buf_last_lane && (sent_cnt == w_total - 1'b1);
    assign final_hs  = buf_pop && sm_tlast;

    // Entries held after this edge plus the read already on the bus; a new read
    // goes out only while that total stays below the two buffer slots.
    assign committed = 3'(buf_count) + 3'(arriving) + 3'(C_rd_en) - 3'(buf_pop);
    assign issue     = ((state == FETCH) || (state == WAIT) || (state == SEND)) &&
                       (committed < 3'd2) && (rd_cnt < w_total);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            w_total  <= '0;
            rd_cnt   <= '0;
            sent_cnt <= '0;
            arriving <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            C_rd_en  <= 1'b0;
            C_index  <= '0;
        end else begin
            C_rd_en  <= 1'b0;
            done     <= 1'b0;
            arriving <= C_rd_en;
            if (buf_pop) begin
                sent_cnt <= sent_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        w_total  <= w_start;
                        sent_cnt <= '0;
                        if (w_start == '0) begin
                            rd_cnt <= '0;
                            state  <= DONE;
                            done   <= 1'b1;
                        end else begin
                            rd_cnt  <= wcnt_t'(1);
                            C_rd_en <= 1'b1;
                            C_index <= '0;
                            busy    <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    if (arriving) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (final_hs) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (issue) begin
                C_rd_en <= 1'b1;
                C_index <= ADDR_BITS'(rd_cnt);
                rd_cnt  <= rd_cnt + 1'b1;
            end
        end
    end

endmodule
